// File: rtl/fp16_mul_pkg.sv
// Shared types, constants and fp16 field classifiers for the fp16 multiplier scheduler.
package fp16_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

  function automatic logic fp16_is_nan(input logic [15:0] x);
    return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic fp16_is_inf(input logic [15:0] x);
    return (x[14:10] == FP16_EXP_MAX) && (x[9:0] == 10'h000);
  endfunction

  // Subnormals are treated as zero: any operand with a zero exponent flushes.
  function automatic logic fp16_is_zero_or_sub(input logic [15:0] x);
    return (x[14:10] == 5'h00);
  endfunction

endpackage

// File: rtl/fp16_special_case.sv
// Combinational resolver for fp16 operand pairs that never need the multiplier datapath.
module fp16_special_case
  import fp16_mul_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        is_special_o,
  output logic [15:0] special_result_o
);

  logic sign;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sign   = a_i[15] ^ b_i[15];
  assign a_nan  = fp16_is_nan(a_i);
  assign b_nan  = fp16_is_nan(b_i);
  assign a_inf  = fp16_is_inf(a_i);
  assign b_inf  = fp16_is_inf(b_i);
  assign a_zero = fp16_is_zero_or_sub(a_i);
  assign b_zero = fp16_is_zero_or_sub(b_i);

  // Priority order matters: Inf x 0 must produce NaN before the Inf rule fires.
  always_comb begin
    is_special_o     = 1'b1;
    special_result_o = FP16_QNAN;
    if (a_nan || b_nan) begin
      special_result_o = FP16_QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      special_result_o = FP16_QNAN;
    end else if (a_inf || b_inf) begin
      special_result_o = {sign, FP16_EXP_MAX, 10'h000};
    end else if (a_zero || b_zero) begin
      special_result_o = {sign, 15'h0000};
    end else begin
      is_special_o     = 1'b0;
      special_result_o = 16'h0000;
    end
  end

endmodule

// File: rtl/fp16_mul_sched.sv
// Two-requester round-robin scheduler for the shared fp16 multiplier; one operation in flight.
// Optional completion counters (stat_cnt0/stat_cnt1) are built when FP16_MUL_SCHED_STATS_EN is defined.
module fp16_mul_sched
  import fp16_mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [15:0] resp0_result,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [15:0] resp1_result,
  output logic [15:0] mul_na,
  output logic [15:0] mul_nb,
  input  logic [15:0] mul_product
`ifdef FP16_MUL_SCHED_STATS_EN
  ,
  output logic [15:0] stat_cnt0,
  output logic [15:0] stat_cnt1
`endif
);

  localparam logic [2:0] LAT = 3'(MUL_LAT);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        id_q, id_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        gnt0, gnt1;
  logic [15:0] sel_a, sel_b;
  logic        is_special;
  logic [15:0] special_result;
  logic        resp_fire;

  // Requester 0 wins unless requester 1 also asks and holds the rr pointer.
  assign gnt0  = (state_q == IDLE) && req0_valid && (!req1_valid || !rr_q);
  assign gnt1  = (state_q == IDLE) && req1_valid && (!req0_valid ||  rr_q);
  assign sel_a = gnt1 ? req1_a : req0_a;
  assign sel_b = gnt1 ? req1_b : req0_b;

  assign resp_fire = (state_q == RESP) && (id_q ? resp1_ready : resp0_ready);

  fp16_special_case u_special (
    .a_i              (sel_a),
    .b_i              (sel_b),
    .is_special_o     (is_special),
    .special_result_o (special_result)
  );

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      id_q     <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      result_q <= 16'h0000;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every _d starts from its register so no branch can leave a latch behind.
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          id_d = gnt1;
          rr_d = ~gnt1;
          a_d  = sel_a;
          b_d  = sel_b;
          if (is_special) begin
            result_d = special_result;
            state_d  = RESP;
          end else begin
            cnt_d   = 3'd0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT) begin
          result_d = mul_product;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (resp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = gnt0;
    req1_ready   = gnt1;
    resp0_valid  = (state_q == RESP) && !id_q;
    resp1_valid  = (state_q == RESP) &&  id_q;
    resp0_result = result_q;
    resp1_result = result_q;
    mul_na       = 16'h0000;
    mul_nb       = 16'h0000;
    if (state_q == ISSUE) begin
      mul_na = a_q;
      mul_nb = b_q;
    end
  end

`ifdef FP16_MUL_SCHED_STATS_EN
  logic [15:0] stat0_q, stat0_d;
  logic [15:0] stat1_q, stat1_d;

  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (resp0_valid && resp0_ready && (stat0_q != 16'hFFFF)) stat0_d = stat0_q + 16'd1;
    if (resp1_valid && resp1_ready && (stat1_q != 16'hFFFF)) stat1_d = stat1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat0_q <= 16'h0000;
      stat1_q <= 16'h0000;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat_cnt0 = stat0_q;
  assign stat_cnt1 = stat1_q;
`endif

endmodule

// File: tb/tb_fp16_mul_sched.sv
// Self-checking bench for fp16_mul_sched: directed test-plan cases plus randomized traffic
// compared every cycle against a transaction-level model of the scheduler.
module tb_fp16_mul_sched;

  localparam int MUL_LAT = 2;
  localparam int PIDX    = (MUL_LAT == 0) ? 0 : MUL_LAT - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [15:0] resp0_result, resp1_result;
  logic [15:0] mul_na, mul_nb, mul_product;
`ifdef FP16_MUL_SCHED_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp16_mul_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp0_result (resp0_result),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp1_result (resp1_result),
    .mul_na       (mul_na),
    .mul_nb       (mul_nb),
    .mul_product  (mul_product)
`ifdef FP16_MUL_SCHED_STATS_EN
    ,
    .stat_cnt0    (stat_cnt0),
    .stat_cnt1    (stat_cnt1)
`endif
  );

  // Bench-owned datapath: truncating fp16 multiply for normal operands.
  function automatic logic [15:0] dp_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    int          e;
    logic [9:0]  m;
    logic        s;
    s = a[15] ^ b[15];
    p = {11'h0, 1'b1, a[9:0]} * {11'h0, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      e = e + 1;
      m = p[20:11];
    end else begin
      m = p[19:10];
    end
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e <= 0)  return {s, 15'h0000};
    return {s, e[4:0], m};
  endfunction

  logic [15:0] pipe [0:7];
  always @(posedge clk) begin
    pipe[0] <= dp_mul(mul_na, mul_nb);
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  always_comb mul_product = (MUL_LAT == 0) ? dp_mul(mul_na, mul_nb) : pipe[PIDX];

  // Reference: {is_special, result} from the fp16 special-operand rules.
  function automatic logic [16:0] ref_special(input logic [15:0] a, input logic [15:0] b);
    logic s;
    bit   an, bn, ai, bi, az, bz;
    s  = a[15] ^ b[15];
    an = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    az = (a[14:10] == 5'h00);
    bz = (b[14:10] == 5'h00);
    if (an || bn)                 return {1'b1, 16'h7E00};
    if ((ai && bz) || (bi && az)) return {1'b1, 16'h7E00};
    if (ai || bi)                 return {1'b1, s, 5'h1F, 10'h000};
    if (az || bz)                 return {1'b1, s, 15'h0000};
    return {1'b0, 16'h0000};
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] x;
    x[15] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       x[14:0] = {5'h1F, 10'h000};
      1:       x[14:0] = {5'h1F, 10'($urandom_range(1, 1023))};
      2:       x[14:0] = 15'h0000;
      3:       x[14:0] = {5'h00, 10'($urandom_range(1, 1023))};
      default: x[14:0] = {5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
    endcase
    return x;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one operation outstanding, compared on every cycle.
  bit          m_busy = 0, m_id = 0, m_spec = 0, m_rr = 0;
  logic [15:0] m_a = '0, m_b = '0, m_res = '0;
  int          m_tacc = 0, m_tresp = 0, cyc = 0;

  initial begin
    bit          e_r0, e_r1, e_v0, e_v1;
    logic [15:0] e_na, e_nb;
    logic [16:0] sp;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        m_busy = 0;
        m_rr   = 0;
        continue;
      end
      e_r0 = !m_busy && req0_valid && (!req1_valid || !m_rr);
      e_r1 = !m_busy && req1_valid && (!req0_valid ||  m_rr);
      e_v0 = m_busy && !m_id && (cyc >= m_tresp);
      e_v1 = m_busy &&  m_id && (cyc >= m_tresp);
      e_na = 16'h0000;
      e_nb = 16'h0000;
      if (m_busy && !m_spec && (cyc > m_tacc) && (cyc <= m_tacc + MUL_LAT + 1)) begin
        e_na = m_a;
        e_nb = m_b;
      end
      check("req0_ready",  16'(req0_ready),  16'(e_r0));
      check("req1_ready",  16'(req1_ready),  16'(e_r1));
      check("resp0_valid", 16'(resp0_valid), 16'(e_v0));
      check("resp1_valid", 16'(resp1_valid), 16'(e_v1));
      check("mul_na", mul_na, e_na);
      check("mul_nb", mul_nb, e_nb);
      if (e_v0) check("resp0_result", resp0_result, m_res);
      if (e_v1) check("resp1_result", resp1_result, m_res);
      if (e_r0 || e_r1) begin
        m_busy  = 1;
        m_id    = e_r1;
        m_a     = e_r1 ? req1_a : req0_a;
        m_b     = e_r1 ? req1_b : req0_b;
        sp      = ref_special(m_a, m_b);
        m_spec  = sp[16];
        m_res   = m_spec ? sp[15:0] : dp_mul(m_a, m_b);
        m_tacc  = cyc;
        m_tresp = cyc + (m_spec ? 1 : MUL_LAT + 2);
        m_rr    = !e_r1;
      end else if (m_busy && (cyc >= m_tresp) && (m_id ? resp1_ready : resp0_ready)) begin
        m_busy = 0;
      end
    end
  end

  function automatic logic rv(input int id);
    return (id == 0) ? resp0_valid : resp1_valid;
  endfunction

  function automatic logic [15:0] rres(input int id);
    return (id == 0) ? resp0_result : resp1_result;
  endfunction

  task automatic drive_req(input int id, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_req(0, 1'b0, 16'h0, 16'h0);
    drive_req(1, 1'b0, 16'h0, 16'h0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one op alone and stop in the first cycle its response is valid.
  task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input int exp_lat,
                        input logic [15:0] exp_na, input string tag);
    int lat;
    @(negedge clk);
    drive_req(id, 1'b1, a, b);
    #2 check({tag, " accept"}, 16'((id == 0) ? req0_ready : req1_ready), 16'd1);
    @(negedge clk);
    drive_req(id, 1'b0, 16'h0, 16'h0);
    lat = 1;
    #2 check({tag, " mul_na"}, mul_na, exp_na);
    while (!rv(id) && lat < 20) begin
      @(negedge clk);
      #2;
      lat++;
    end
    check({tag, " latency"}, 16'(lat), 16'(exp_lat));
    check({tag, " result"}, rres(id), exp_res);
  endtask

  task automatic finish_resp(input int id);
    @(negedge clk);
    if (id == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  initial begin
    int g [4];
    int n;
    do_reset();
    #2;
    check("reset req0_ready", 16'(req0_ready), 16'd0);
    check("reset resp0_valid", 16'(resp0_valid), 16'd0);
    check("reset resp1_valid", 16'(resp1_valid), 16'd0);
    check("reset mul_na", mul_na, 16'h0000);
    check("reset resp0_result", resp0_result, 16'h0000);

    run_op(0, 16'h3E00, 16'h4000, 16'h4200, MUL_LAT + 2, 16'h3E00, "normal r0");
    finish_resp(0);
    run_op(1, 16'h7C00, 16'h0000, 16'h7E00, 1, 16'h0000, "inf*0 r1");
    finish_resp(1);
    run_op(0, 16'h8001, 16'h3C00, 16'h8000, 1, 16'h0000, "sub flush");
    finish_resp(0);
    run_op(0, 16'hFC00, 16'h3C00, 16'hFC00, 1, 16'h0000, "neg inf");
    finish_resp(0);
    run_op(0, 16'h7E01, 16'h3C00, 16'h7E00, 1, 16'h0000, "nan");
    finish_resp(0);

    // Back-pressure: response held 5 cycles while requester 1 waits.
    run_op(0, 16'h4000, 16'h4000, 16'h4400, MUL_LAT + 2, 16'h4000, "hold r0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_req(1, 1'b1, 16'h3C00, 16'h4000);
      #2;
      check("hold valid", 16'(resp0_valid), 16'd1);
      check("hold result", resp0_result, 16'h4400);
      check("hold req1_ready", 16'(req1_ready), 16'd0);
    end
    @(negedge clk);
    resp0_ready = 1'b1;
    #2 check("handshake req1_ready", 16'(req1_ready), 16'd0);
    @(negedge clk);
    resp0_ready = 1'b0;
    #2 check("post-handshake req1_ready", 16'(req1_ready), 16'd1);
    @(negedge clk);
    drive_req(1, 1'b0, 16'h0, 16'h0);
    resp1_ready = 1'b1;
    repeat (MUL_LAT + 4) @(negedge clk);
    resp1_ready = 1'b0;

    // Alternating grants with both requesters continuously valid.
    do_reset();
    drive_req(0, 1'b1, 16'h3C00, 16'h3C00);
    drive_req(1, 1'b1, 16'h0000, 16'h4000);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      #2;
      if (req0_ready)      begin g[n] = 0; n++; end
      else if (req1_ready) begin g[n] = 1; n++; end
      @(negedge clk);
    end
    check("alternation grant count", 16'(n), 16'd4);
    for (int i = 0; i < n; i++) check("alternation grant id", 16'(g[i]), 16'(i % 2));
    drive_req(0, 1'b0, 16'h0, 16'h0);
    drive_req(1, 1'b0, 16'h0, 16'h0);
    repeat (MUL_LAT + 4) @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;

    // Reset during ISSUE abandons the operation.
    @(negedge clk);
    drive_req(0, 1'b1, 16'h3E00, 16'h4000);
    @(negedge clk);
    drive_req(0, 1'b0, 16'h0, 16'h0);
    #2 check("pre-reset mul_na", mul_na, 16'h3E00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("midop reset resp0_valid", 16'(resp0_valid), 16'd0);
    check("midop reset mul_na", mul_na, 16'h0000);
    check("midop reset mul_nb", mul_nb, 16'h0000);
    check("midop reset result", resp0_result, 16'h0000);
    check("midop reset req1_ready", 16'(req1_ready), 16'd0);
    repeat (MUL_LAT + 4) begin
      @(negedge clk);
      #2 check("abandoned resp0_valid", 16'(resp0_valid), 16'd0);
    end

`ifdef FP16_MUL_SCHED_STATS_EN
    do_reset();
    #2 check("stat_cnt0 reset", stat_cnt0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      run_op(0, 16'h0000, 16'h3C00, 16'h0000, 1, 16'h0000, "stat op");
      finish_resp(0);
    end
    #2;
    check("stat_cnt0", stat_cnt0, 16'd3);
    check("stat_cnt1", stat_cnt1, 16'd0);
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n       = ($urandom_range(0, 499) != 0);
      req0_valid  = ($urandom_range(0, 9) < 7);
      req1_valid  = ($urandom_range(0, 9) < 7);
      req0_a      = rand_fp();
      req0_b      = rand_fp();
      req1_a      = rand_fp();
      req1_b      = rand_fp();
      resp0_ready = ($urandom_range(0, 9) < 6);
      resp1_ready = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(0, 1'b0, 16'h0, 16'h0);
    drive_req(1, 1'b0, 16'h0, 16'h0);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (MUL_LAT + 5) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16_mul_sched.md
Name: fp16_mul_sched

Overview:
Two-requester scheduler for the shared IEEE-754 half-precision multiplier datapath. It accepts operand pairs over valid/ready, grants round-robin, and resolves special operands (NaN, Inf, zero, subnormal flushed to zero) locally. Only normal x normal pairs go to the datapath. The result returns on the granted requester's response channel, with one operation in flight at a time.

Parameters:
MUL_LAT, 1, cycles from operands driven on mul_na/mul_nb to mul_product valid; legal 0..7; 0 means a combinational multiplier.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 operand pair valid
req0_ready  out  1  requester 0 accepted this cycle
req0_a  in  16  requester 0 operand A (fp16)
req0_b  in  16  requester 0 operand B (fp16)
resp0_valid  out  1  requester 0 result valid
resp0_ready  in  1  requester 0 takes result
resp0_result  out  16  requester 0 product (fp16)
req1_valid, req1_ready, req1_a, req1_b, resp1_valid, resp1_ready, resp1_result: same as requester 0, for requester 1
mul_na  out  16  operand A to multiplier datapath
mul_nb  out  16  operand B to multiplier datapath
mul_product  in  16  multiplier result, sampled MUL_LAT cycles after issue

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE; rr pointer 0 (requester 0 has priority).
  - All ready/valid outputs 0; resp*_result, mul_na, mul_nb 16'h0000; latency counter 0.
  - Reset mid-operation abandons the operation with no response.
- States and transitions:
  - IDLE: req*_ready is combinational, asserted only in IDLE, for at most one requester.
    - Both requesters valid: grant the rr pointer's requester. Pointer moves to the other requester after every grant.
    - Only one valid: grant it.
    - On grant: latch a, b and the grant id. Classify the pair.
    - Special pair: go to RESP with the computed result.
    - Normal pair: go to ISSUE with the counter cleared.
  - ISSUE: mul_na/mul_nb driven from the latched operands; outside ISSUE both are 16'h0000.
    - Counter increments each cycle.
    - When counter == MUL_LAT: latch mul_product into the result register and go to RESP.
  - RESP: resp{id}_valid = 1 and resp{id}_result held stable until resp{id}_ready, then go to IDLE.
    - No accept occurs in the RESP cycle, so the minimum gap between operations is 1 IDLE cycle.
    - The other requester's resp_valid stays 0.
- Latency from accept edge to resp_valid: special pair 1 cycle; normal pair MUL_LAT+2 cycles.
- Classification, in priority order. Let sign = a[15]^b[15].
  - Either operand NaN (exp 5'h1F, mant != 0): result 16'h7E00.
  - Inf x zero-or-subnormal: result 16'h7E00.
  - Either operand Inf: result {sign,5'h1F,10'h0}.
  - Either operand zero or subnormal (exp 0), flush to zero: result {sign,15'h0}.
  - Otherwise the pair is normal and is issued to the datapath.
- mul_product is passed through unmodified; overflow and rounding are owned by the datapath.
- Holding req_valid with changing data while req_ready is low is legal. Only the data present in the accept cycle is used.

Optional Feature:
FP16_MUL_SCHED_STATS_EN
- Defined: adds output ports stat_cnt0 and stat_cnt1, 16 bits each.
  - Each counts completed responses (resp_valid && resp_ready) for its requester.
  - Each saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: no ports and no counter logic; the interface is otherwise identical.

Decomposition:
- Package fp16_mul_pkg:
  - state enum (IDLE, ISSUE, RESP);
  - constants FP16_QNAN = 16'h7E00, FP16_EXP_MAX = 5'h1F;
  - function fp16_is_nan, fp16_is_inf, fp16_is_zero_or_sub.
- Sub-module fp16_special_case: combinational, takes a and b, outputs is_special and special_result.

Test Plan:
- MUL_LAT=2, bench model multiplier; req0 0x3E00 x 0x4000 -> resp0_result 0x4200, resp0_valid exactly 4 cycles after accept, mul_na=0x3E00 during ISSUE.
- req1 0x7C00 x 0x0000 -> resp1_result 0x7E00 one cycle after accept; mul_na/mul_nb stay 0x0000.
- req0 0x8001 x 0x3C00 -> 0x8000; req0 0xFC00 x 0x3C00 -> 0xFC00; req0 0x7E01 x 0x3C00 -> 0x7E00.
- Both valid continuously after reset -> grants alternate 0,1,0,1; each response only on the granted channel.
- resp0_ready held low 5 cycles -> result and valid stable; req1 not accepted until 1 cycle after the handshake completes.
- rst_n low during ISSUE -> next cycle all outputs zero, state IDLE, no resp_valid; with FP16_MUL_SCHED_STATS_EN, 3 completions on req0 -> stat_cnt0 = 3.
